stream_pkt_arbiter: RTL and testbench

STREAM_PKT_ARBITER -- requirements
Module: stream_pkt_arbiter

---
 rtl/stream_pkt_arbiter.sv | 157 +++++++++++++++
 tb/tb_stream_pkt_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_pkt_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stream_pkt_arbiter                                                         |
// | Round-robin packet arbiter: N AXI-stream ports onto one, with truncation.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module stream_pkt_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int TDATA_WIDTH   = 64,
  parameter int MAX_PKT_BEATS = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0]                 s_tvalid,
  output logic [NUM_PORTS-1:0]                 s_tready,
  input  logic [NUM_PORTS-1:0]                 s_tlast,
  input  logic [NUM_PORTS*TDATA_WIDTH-1:0]     s_tdata,
  input  logic [NUM_PORTS*TDATA_WIDTH/8-1:0]   s_tkeep,
  input  logic [NUM_PORTS-1:0]                 s_tuser,
  output logic                                 m_tvalid,
  input  logic                                 m_tready,
  output logic                                 m_tlast,
  output logic [TDATA_WIDTH-1:0]               m_tdata,
  output logic [TDATA_WIDTH/8-1:0]             m_tkeep,
  output logic                                 m_tuser,
  output logic [$clog2(NUM_PORTS)-1:0]         m_tid,
  output logic [15:0]                          pkt_cnt,
  output logic [15:0]                          trunc_cnt
);
  localparam int C_IDW = $clog2(NUM_PORTS);
  localparam int C_KW  = TDATA_WIDTH / 8;
  localparam logic [15:0]      C_LIMIT     = 16'(MAX_PKT_BEATS - 1);
  localparam logic [C_IDW-1:0] C_LAST_PORT = C_IDW'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [C_IDW-1:0] grant_q, grant_d;
  logic [C_IDW-1:0] last_grant_q, last_grant_d;
  logic [15:0]      beat_cnt_q, beat_cnt_d;
  logic [15:0]      pkt_cnt_q, pkt_cnt_d;
  logic [15:0]      trunc_cnt_q, trunc_cnt_d;

  logic                   w_sel_valid;
  logic                   w_sel_last;
  logic                   w_sel_user;
  logic [TDATA_WIDTH-1:0] w_sel_data;
  logic [C_KW-1:0]        w_sel_keep;
  logic                   w_at_limit;
  logic                   w_rr_found;
  logic [C_IDW-1:0]       w_rr_pick;
  logic [C_IDW-1:0]       w_rr_cand;

  assign w_sel_valid = s_tvalid[grant_q];
  assign w_sel_last  = s_tlast[grant_q];
  assign w_sel_user  = s_tuser[grant_q];
  assign w_sel_data  = s_tdata[grant_q*TDATA_WIDTH +: TDATA_WIDTH];
  assign w_sel_keep  = s_tkeep[grant_q*C_KW +: C_KW];
  assign w_at_limit  = (beat_cnt_q == C_LIMIT);

  assign m_tdata   = w_sel_data;
  assign m_tkeep   = w_sel_keep;
  assign m_tid     = grant_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign trunc_cnt = trunc_cnt_q;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_pick  = last_grant_q;
    w_rr_cand  = last_grant_q;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_rr_cand = C_IDW'((int'(last_grant_q) + k) % NUM_PORTS);
      if (!w_rr_found && s_tvalid[w_rr_cand]) begin
        w_rr_found = 1'b1;
        w_rr_pick  = w_rr_cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    pkt_cnt_d    = pkt_cnt_q;
    trunc_cnt_d  = trunc_cnt_q;
    s_tready     = '0;
    m_tvalid     = 1'b0;
    m_tlast      = 1'b0;
    m_tuser      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (w_rr_found) begin
          grant_d = w_rr_pick;
          state_d = PASS;
        end
      end
      PASS: begin
        m_tvalid          = w_sel_valid;
        s_tready[grant_q] = m_tready;
        // A beat at the limit without its own tlast is forced to close the packet.
        m_tlast           = w_sel_last | w_at_limit;
        m_tuser           = w_sel_user | (w_at_limit & ~w_sel_last);
        if (w_sel_valid && m_tready) begin
          if (w_sel_last) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
            beat_cnt_d   = '0;
            pkt_cnt_d    = pkt_cnt_q + 16'd1;
          end else if (w_at_limit) begin
            state_d   = DRAIN;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            if (trunc_cnt_q != 16'hFFFF) begin
              trunc_cnt_d = trunc_cnt_q + 16'd1;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 16'd1;
          end
        end
      end
      DRAIN: begin
        s_tready[grant_q] = 1'b1;
        if (w_sel_valid && w_sel_last) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
          beat_cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= C_LAST_PORT;
      beat_cnt_q   <= '0;
      pkt_cnt_q    <= '0;
      trunc_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      pkt_cnt_q    <= pkt_cnt_d;
      trunc_cnt_q  <= trunc_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_pkt_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_stream_pkt_arbiter                                                      |
// | Directed and randomized bench with a packet-level reference model.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_stream_pkt_arbiter;
  localparam int NP   = 4;
  localparam int W    = 64;
  localparam int KW   = 8;
  localparam int MAXB = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NP-1:0]   s_tvalid = '0;
  logic [NP-1:0]   s_tready;
  logic [NP-1:0]   s_tlast = '0;
  logic [NP*W-1:0] s_tdata = '0;
  logic [NP*KW-1:0] s_tkeep = '0;
  logic [NP-1:0]   s_tuser = '0;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic            m_tlast;
  logic [W-1:0]    m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tuser;
  logic [1:0]      m_tid;
  logic [15:0]     pkt_cnt;
  logic [15:0]     trunc_cnt;

  stream_pkt_arbiter #(.NUM_PORTS(NP), .TDATA_WIDTH(W), .MAX_PKT_BEATS(MAXB)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tid(m_tid),
    .pkt_cnt(pkt_cnt), .trunc_cnt(trunc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [63:0] d; logic [7:0] k; logic l; logic u;} beat_t;
  typedef struct packed {logic [63:0] d; logic [7:0] k; logic l; logic u; logic [1:0] id;} obeat_t;

  beat_t  pq[NP][$];
  obeat_t olog[$];
  int total = 0;
  int bad   = 0;
  int vmode = 0;   // 0: sources always valid, 1: random gaps
  int trmode = 0;  // 0: sink always ready, 1: toggle, 2: random
  int cyc = 0;
  int rise_cyc = 0;

  // Reference model: which port owns the output, how many beats it has sent, and
  // whether the rest of its packet is being thrown away.
  int own = -1;
  bit drop = 0;
  int nb = 0;
  int lastg = NP - 1;
  int mp = 0;
  int mt = 0;
  int tidr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick();
    for (int k = 1; k <= NP; k++) begin
      if (s_tvalid[(lastg + k) % NP]) return (lastg + k) % NP;
    end
    return -1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      own = -1; drop = 0; nb = 0; lastg = NP - 1; mp = 0; mt = 0; tidr = 0;
    end else if (own < 0) begin
      own = rr_pick();
      if (own >= 0) begin tidr = own; nb = 0; drop = 0; end
    end else if (!drop) begin
      if (s_tvalid[own] && m_tready) begin
        if (s_tlast[own]) begin
          lastg = own; own = -1; mp = (mp + 1) % 65536;
        end else if (nb == MAXB - 1) begin
          drop = 1; mp = (mp + 1) % 65536;
          if (mt < 65535) mt++;
        end else begin
          nb++;
        end
      end
    end else if (s_tvalid[own] && s_tlast[own]) begin
      lastg = own; own = -1;
    end
  end

  logic          exp_valid;
  logic [NP-1:0] exp_ready;
  logic          lim;
  logic          prev_mv = 1'b0;

  initial forever begin
    @(negedge clk);
    exp_valid = 1'b0;
    exp_ready = '0;
    if (own >= 0 && !drop) begin
      exp_valid = s_tvalid[own];
      exp_ready[own] = m_tready;
    end else if (own >= 0) begin
      exp_ready[own] = 1'b1;
    end
    chk("m_tvalid", 64'(m_tvalid), 64'(exp_valid));
    chk("s_tready", 64'(s_tready), 64'(exp_ready));
    chk("m_tid", 64'(m_tid), 64'(tidr));
    chk("pkt_cnt", 64'(pkt_cnt), 64'(mp));
    chk("trunc_cnt", 64'(trunc_cnt), 64'(mt));
    if (exp_valid) begin
      lim = (nb == MAXB - 1);
      chk("m_tdata", m_tdata, s_tdata[own*W +: W]);
      chk("m_tkeep", 64'(m_tkeep), 64'(s_tkeep[own*KW +: KW]));
      chk("m_tlast", 64'(m_tlast), 64'(s_tlast[own] | lim));
      chk("m_tuser", 64'(m_tuser), 64'(s_tuser[own] | (lim & ~s_tlast[own])));
    end
    if (m_tvalid && !prev_mv) rise_cyc = cyc;
    prev_mv = m_tvalid;
    if (m_tvalid && m_tready) olog.push_back(obeat_t'({m_tdata, m_tkeep, m_tlast, m_tuser, m_tid}));
  end

  task automatic cycle();
    logic [NP-1:0] hs;
    @(negedge clk);
    hs = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (hs[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      if (pq[i].size() == 0) begin
        s_tvalid[i] = 1'b0;
      end else begin
        if (hs[i] || !s_tvalid[i]) s_tvalid[i] = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        s_tdata[i*W +: W]   = pq[i][0].d;
        s_tkeep[i*KW +: KW] = pq[i][0].k;
        s_tlast[i]          = pq[i][0].l;
        s_tuser[i]          = pq[i][0].u;
      end
    end
    case (trmode)
      0: m_tready = 1'b1;
      1: m_tready = ~m_tready;
      default: m_tready = ($urandom_range(0, 2) != 0);
    endcase
  endtask

  task automatic push(input int p, input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    beat_t b;
    b.d = d; b.k = k; b.l = l; b.u = u;
    pq[p].push_back(b);
  endtask

  task automatic push_pkt(input int p, input int len, input logic u);
    for (int j = 0; j < len; j++)
      push(p, {$urandom, $urandom}, (j == len - 1) ? 8'($urandom_range(1, 255)) : 8'hFF, j == len - 1, u && (j == len - 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NP; i++) pq[i].delete();
    s_tvalid = '0;
    trmode = 0;
    repeat (2) cycle();
    rst = 1'b0;
    olog.delete();
  endtask

  task automatic wait_log(input int n, input int budget);
    int c;
    c = 0;
    while (olog.size() < n && c < budget) begin cycle(); c++; end
    chk("beats_delivered_in_time", 64'(olog.size() >= n), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  beat_t ref_q[$];
  int eo[4] = '{0, 1, 3, 0};
  int npk, ntr, len, c;
  logic busy;

  initial begin
    // Single port, two beats, one-cycle arbitration latency
    do_reset();
    chk("reset_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("reset_m_tid", 64'(m_tid), 64'd0);
    push(0, 64'habcddcef_00080001, 8'hFF, 1'b0, 1'b0);
    push(0, 64'h00000000_630d658d, 8'h0F, 1'b1, 1'b0);
    cycle();
    c = cyc;
    wait_log(2, 20);
    chk("t1_latency", 64'(rise_cyc - c), 64'd1);
    chk("t1_beat0", olog[0].d, 64'habcddcef_00080001);
    chk("t1_beat1", olog[1].d, 64'h00000000_630d658d);
    chk("t1_keep1", 64'(olog[1].k), 64'h0F);
    chk("t1_tid", 64'(olog[0].id), 64'd0);
    chk("t1_last", 64'(olog[1].l), 64'd1);
    chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);

    // Contention: 0, 1, 3 then 0 again, no interleaving
    do_reset();
    push_pkt(0, 3, 1'b0); push_pkt(1, 3, 1'b0); push_pkt(3, 3, 1'b0); push_pkt(0, 3, 1'b0);
    wait_log(12, 100);
    for (int b = 0; b < 12 && b < olog.size(); b++) chk("t2_grant_order", 64'(olog[b].id), 64'(eo[b/3]));

    // Backpressure on an exact-limit packet
    do_reset();
    push_pkt(2, 4, 1'b0);
    ref_q = pq[2];
    trmode = 1;
    wait_log(4, 40);
    trmode = 0;
    for (int b = 0; b < 4 && b < olog.size(); b++) begin
      chk("t3_data_order", olog[b].d, ref_q[b].d);
      chk("t3_user", 64'(olog[b].u), 64'd0);
      chk("t3_last", 64'(olog[b].l), 64'(b == 3));
    end
    chk("t3_trunc_cnt", 64'(trunc_cnt), 64'd0);

    // Truncation of a 6-beat packet, then a single-beat packet
    do_reset();
    push_pkt(2, 6, 1'b0);
    push_pkt(3, 1, 1'b1);
    wait_log(5, 60);
    if (olog.size() >= 5) begin
      chk("t4_beat3_last", 64'(olog[2].l), 64'd0);
      chk("t4_beat4_last", 64'(olog[3].l), 64'd1);
      chk("t4_beat4_user", 64'(olog[3].u), 64'd1);
      chk("t4_next_tid", 64'(olog[4].id), 64'd3);
      chk("t4_single_user", 64'(olog[4].u), 64'd1);
    end
    chk("t4_trunc_cnt", 64'(trunc_cnt), 64'd1);
    chk("t4_pkt_cnt", 64'(pkt_cnt), 64'd2);

    // Reset in the middle of a packet
    do_reset();
    push_pkt(0, 5, 1'b0);
    wait_log(2, 20);
    rst = 1'b1;
    for (int i = 0; i < NP; i++) pq[i].delete();
    s_tvalid = '0;
    cycle();
    chk("t5_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("t5_s_tready", 64'(s_tready), 64'd0);
    chk("t5_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("t5_m_tid", 64'(m_tid), 64'd0);
    rst = 1'b0;
    olog.delete();
    push_pkt(1, 2, 1'b0);
    wait_log(2, 20);
    if (olog.size() >= 2) begin
      chk("t5_first_tid", 64'(olog[0].id), 64'd1);
      chk("t5_last", 64'(olog[1].l), 64'd1);
    end

    // Randomized traffic against the model
    do_reset();
    vmode = 1; trmode = 2; npk = 0; ntr = 0;
    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(1, 7);
      push_pkt($urandom_range(0, NP - 1), len, ($urandom_range(0, 7) == 0));
      npk++;
      if (len > MAXB) ntr++;
    end
    c = 0;
    busy = 1'b1;
    while (busy && c < 3000) begin
      cycle(); c++;
      busy = (own >= 0);
      for (int i = 0; i < NP; i++) if (pq[i].size() != 0) busy = 1'b1;
    end
    chk("t6_drained", 64'(busy), 64'd0);
    cycle();
    chk("t6_pkt_cnt", 64'(pkt_cnt), 64'(npk));
    chk("t6_trunc_cnt", 64'(trunc_cnt), 64'(ntr));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
